// File: rtl/wr_ptr_handler.sv
// Write-side pointer logic for the asynchronous FIFO: binary/Gray write pointers
// and a registered full flag derived from the wclk-synchronized Gray read pointer.
module wr_ptr_handler #(
  parameter int PTR_WIDTH = 4
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 w_en,
  input  logic [PTR_WIDTH-1:0] gray_rptr,
  output logic [PTR_WIDTH-1:0] binary_wptr,
  output logic [PTR_WIDTH-1:0] gray_wptr,
  output logic                 full
);

  // Inverting the two MSBs of the read Gray pointer gives the write Gray value one full lap ahead.
  localparam logic [PTR_WIDTH-1:0] FULL_MASK = PTR_WIDTH'(3) << (PTR_WIDTH - 2);

  logic                 wr_accept;
  logic [PTR_WIDTH-1:0] bin_next;
  logic [PTR_WIDTH-1:0] gray_next;
  logic                 full_next;

  always_comb begin
    wr_accept = w_en & ~full;
    bin_next  = binary_wptr + PTR_WIDTH'(wr_accept);
    gray_next = bin_next ^ (bin_next >> 1);
    full_next = (gray_next == (gray_rptr ^ FULL_MASK));
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      binary_wptr <= '0;
      gray_wptr   <= '0;
      full        <= 1'b0;
    end else begin
      binary_wptr <= bin_next;
      gray_wptr   <= gray_next;
      full        <= full_next;
    end
  end

endmodule

// File: tb/tb_wr_ptr_handler.sv
// Directed self-checking bench for wr_ptr_handler at PTR_WIDTH=4 (depth 8).
module tb_wr_ptr_handler;

  localparam int PW = 4;

  logic          wclk;
  logic          wrst_n;
  logic          w_en;
  logic [PW-1:0] gray_rptr;
  logic [PW-1:0] binary_wptr;
  logic [PW-1:0] gray_wptr;
  logic          full;

  int assert_count = 0;
  int fail_count   = 0;

  wr_ptr_handler #(.PTR_WIDTH(PW)) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .w_en        (w_en),
    .gray_rptr   (gray_rptr),
    .binary_wptr (binary_wptr),
    .gray_wptr   (gray_wptr),
    .full        (full)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic applyStimulus(input logic en, input logic [PW-1:0] rptr_bin);
    w_en      = en;
    gray_rptr = to_gray(rptr_bin);
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [PW-1:0] exp_bin,
                             input logic [PW-1:0] exp_gray, input logic exp_full);
    assert_count++;
    assert (binary_wptr === exp_bin) else begin
      fail_count++;
      $error("[TB] FAIL %s binary_wptr: observed %b expected %b", tag, binary_wptr, exp_bin);
    end
    assert_count++;
    assert (gray_wptr === exp_gray) else begin
      fail_count++;
      $error("[TB] FAIL %s gray_wptr: observed %b expected %b", tag, gray_wptr, exp_gray);
    end
    assert_count++;
    assert (full === exp_full) else begin
      fail_count++;
      $error("[TB] FAIL %s full: observed %b expected %b", tag, full, exp_full);
    end
  endtask

  logic [PW-1:0] fill_gray [8];
  logic [PW-1:0] exp_bin;
  logic [PW-1:0] rd_bin;

  initial begin
    fill_gray = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};

    // Reset held from time 0, visible before any clock edge
    wrst_n = 1'b0;
    applyStimulus(1'b0, 4'd0);
    #1;
    checkOutput("reset_pre_edge", 4'b0000, 4'b0000, 1'b0);
    #63;
    checkOutput("reset_held", 4'b0000, 4'b0000, 1'b0);
    @(negedge wclk);
    wrst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("idle_from_reset", 4'b0000, 4'b0000, 1'b0);
    end

    // Fill: 8 writes reach full, remaining 7 requests are blocked
    applyStimulus(1'b1, 4'd0);
    for (int i = 1; i <= 15; i++) begin
      step();
      if (i <= 8)
        checkOutput($sformatf("fill_%0d", i), PW'(i), fill_gray[i-1], i == 8);
      else
        checkOutput($sformatf("fill_blocked_%0d", i), 4'b1000, 4'b1100, 1'b1);
    end

    // Unknown write request while full must not disturb the pointers
    w_en = 1'bx;
    for (int i = 0; i < 2; i++) begin
      step();
      checkOutput("full_wen_x", 4'b1000, 4'b1100, 1'b1);
    end

    applyStimulus(1'b0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("idle_full", 4'b1000, 4'b1100, 1'b1);
    end

    // Read side frees one entry: full drops, then one write refills it
    applyStimulus(1'b1, 4'd1);
    step();
    checkOutput("drain_release", 4'b1000, 4'b1100, 1'b0);
    step();
    checkOutput("drain_refill", 4'b1001, 4'b1101, 1'b1);

    // Second lap and beyond: read pointer advances one, write follows and refills
    exp_bin = 4'b1001;
    rd_bin  = 4'd1;
    for (int k = 0; k < 16; k++) begin
      rd_bin = rd_bin + 4'd1;
      applyStimulus(1'b1, rd_bin);
      step();
      checkOutput($sformatf("wrap_release_%0d", k), exp_bin, to_gray(exp_bin), 1'b0);
      exp_bin = exp_bin + 4'd1;
      step();
      checkOutput($sformatf("wrap_write_%0d", k), exp_bin, to_gray(exp_bin), 1'b1);
    end
    checkOutput("wrap_final", 4'b1001, 4'b1101, 1'b1);

    // Explicit wrap point: from 1111/1000 the next write lands on 0000/0000
    @(negedge wclk);
    wrst_n = 1'b0;
    #1;
    checkOutput("reset_from_full", 4'b0000, 4'b0000, 1'b0);
    @(negedge wclk);
    wrst_n = 1'b1;
    applyStimulus(1'b1, 4'd8);
    for (int i = 1; i <= 15; i++) step();
    checkOutput("pre_wrap", 4'b1111, 4'b1000, 1'b0);
    step();
    checkOutput("wrap_to_zero", 4'b0000, 4'b0000, 1'b1);

    // Async reset between edges after 5 writes
    @(negedge wclk);
    wrst_n = 1'b0;
    @(negedge wclk);
    wrst_n = 1'b1;
    applyStimulus(1'b1, 4'd0);
    for (int i = 0; i < 5; i++) step();
    checkOutput("mid_fill_5", 4'b0101, 4'b0111, 1'b0);
    @(negedge wclk);
    wrst_n = 1'b0;
    #1;
    checkOutput("async_reset_immediate", 4'b0000, 4'b0000, 1'b0);
    step();
    checkOutput("async_reset_held", 4'b0000, 4'b0000, 1'b0);
    @(negedge wclk);
    wrst_n = 1'b1;
    step();
    checkOutput("resume_1", 4'b0001, 4'b0001, 1'b0);
    step();
    checkOutput("resume_2", 4'b0010, 4'b0011, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/wr_ptr_handler.md
Name: wr_ptr_handler

Overview:
- Write-domain pointer block of the asynchronous FIFO.
- Keeps the write pointer in binary and Gray code, both clocked by wclk.
- Binary pointer addresses the FIFO memory; Gray pointer is handed to the read-domain synchronizer.
- Generates the registered full flag by comparing the next Gray write pointer with the read pointer, which has already been synchronized into wclk.

Parameters:
- PTR_WIDTH, default 4: pointer width = address bits + 1. FIFO depth = 2^(PTR_WIDTH-1), so 8 at default. Legal range is PTR_WIDTH >= 2.

Ports:
- wclk  input  1  write-domain clock; all state updates on the rising edge.
- wrst_n  input  1  reset, asynchronous, active-low. Clock is wclk, reset is wrst_n: one clock, asynchronous active-low reset.
- w_en  input  1  write request for the current cycle.
- gray_rptr  input  PTR_WIDTH  read pointer in Gray code, already synchronized into the wclk domain.
- binary_wptr  output  PTR_WIDTH  registered binary write pointer. The memory write address is binary_wptr[PTR_WIDTH-2:0].
- gray_wptr  output  PTR_WIDTH  registered Gray write pointer.
- full  output  1  registered FIFO-full flag.

Behaviour:
- Reset (wrst_n=0, takes effect immediately, no clock needed):
  - binary_wptr=0, gray_wptr=0, full=0.
  - Outputs hold these values while reset is asserted.
  - Deasserting reset mid-operation restarts the pointers from 0.
- Write accept: wr_accept = w_en & ~full, using the registered full.
- Next-state logic:
  - bin_next = binary_wptr + wr_accept, modulo 2^PTR_WIDTH. It wraps from all-ones to 0 with no saturation.
  - gray_next = bin_next ^ (bin_next >> 1).
- Every rising wclk edge: binary_wptr <= bin_next, gray_wptr <= gray_next, full <= full_next.
  - Latency is one cycle from w_en sampled high to the pointer change.
  - gray_wptr is always the Gray encoding of binary_wptr in the same cycle.
- Full detection:
  - full_next = (gray_next == {~gray_rptr[PTR_WIDTH-1], ~gray_rptr[PTR_WIDTH-2], gray_rptr[PTR_WIDTH-3:0]}).
  - For PTR_WIDTH=2 the low slice is empty.
  - full therefore asserts on the same edge that accepts the write filling the last free entry.
- While full=1:
  - w_en is ignored and the pointers hold.
  - full is re-evaluated every cycle against gray_rptr.
  - full deasserts one edge after gray_rptr advances past the full condition.
- Simultaneous events:
  - A gray_rptr change and a write in the same cycle are both reflected in full_next at the next edge.
  - The comparison uses the current gray_rptr sample.
- No combinational path from any input to any output. All outputs are flops.
- gray_rptr is not synchronized inside this block; two-flop synchronization is the caller's responsibility.
- No X propagation out of reset. w_en=X while full=1 must not corrupt the pointers; the bench checks this.

Test Plan:
- Reset: hold wrst_n=0 for 64 time units with w_en=0 and gray_rptr=0 -> binary_wptr=0000, gray_wptr=0000, full=0 throughout, including before the first clock edge.
- Fill: after reset, gray_rptr=0, w_en=1 for 15 edges ->
  - binary_wptr steps 0001..1000, gray_wptr 0001,0011,0010,0110,0111,0101,0100,1100.
  - full=1 on the 8th edge.
  - Pointers stay at 1000/1100 for the remaining 7 edges.
- Hold when idle: w_en=0 for 10 edges after the fill -> pointers and full unchanged. Separately, w_en=0 from reset -> pointers stay 0.
- Drain release: from the full state, set gray_rptr=0001 -> full=0 at the next edge. With w_en=1, one more write gives binary_wptr=1001, gray_wptr=1101, and full=1 again at that edge.
- Wrap-around: keep gray_rptr tracking 8 behind by updating the read pointer, and write 16+ times -> binary_wptr wraps 1111->0000, gray_wptr 1000->0000, and full behaves identically on the second lap.
- Async reset mid-fill: assert wrst_n=0 between edges after 5 writes -> all outputs go to 0 immediately, before the next edge. On release, writing resumes from 0.
